// File: rtl/mac_window_feeder.sv
// -----------------------------------------------------------------------------
// mac_window_feeder
//
// Upstream feeder for the CPE matrix accelerator. Collects a serial stream of
// (multiplier, multiplicand) pairs into KERNEL_SIZE*KERNEL_SIZE operand slots.
// Once a correctly framed window is complete it pulses mStart on every lane,
// waits for the accelerator's finalReady, and hands finalAccumulate back on a
// valid/ready result port.
//
// Ports
//   Clk                 clock, all logic on the rising edge
//   Rst                 synchronous active-low reset
//   s_valid/s_ready     operand stream handshake
//   s_multiplier        signed operand A, DATA_WIDTH bits
//   s_multiplicand      signed operand B, DATA_WIDTH bits
//   s_last              marks the final pair of a window
//   multiplier_input    N slots of AXI_BUS_WIDTH, slot n at [n*AXI_BUS_WIDTH +: AXI_BUS_WIDTH]
//   multiplicand_input  same packing as multiplier_input
//   mStart              all lanes high for one cycle per complete window
//   finalReady          accelerator done
//   finalAccumulate     accelerator sum, captured into m_data
//   m_valid/m_ready     result handshake
//   m_data              captured result
//   busy                high whenever the feeder is not collecting operands
//   frame_err           sticky: window length did not match s_last framing
//   timeout_err         sticky: accelerator never reported done
//   err_clr             clears both sticky flags on the next edge
// -----------------------------------------------------------------------------
module mac_window_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int AXI_BUS_WIDTH = 32,
  parameter int START_GUARD   = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                                              Clk,
  input  logic                                              Rst,
  input  logic                                              s_valid,
  output logic                                              s_ready,
  input  logic [DATA_WIDTH-1:0]                             s_multiplier,
  input  logic [DATA_WIDTH-1:0]                             s_multiplicand,
  input  logic                                              s_last,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]  multiplier_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]  multiplicand_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                mStart,
  input  logic                                              finalReady,
  input  logic [AXI_BUS_WIDTH-1:0]                          finalAccumulate,
  output logic                                              m_valid,
  input  logic                                              m_ready,
  output logic [AXI_BUS_WIDTH-1:0]                          m_data,
  output logic                                              busy,
  output logic                                              frame_err,
  output logic                                              timeout_err,
  input  logic                                              err_clr
);

  localparam int N       = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int GUARD_W = $clog2(START_GUARD + 1);
  localparam int TMO_W   = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(N - 1);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(START_GUARD);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [GUARD_W-1:0]   guard_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [AXI_BUS_WIDTH-1:0] slot_a [N];
  logic [AXI_BUS_WIDTH-1:0] slot_b [N];

  // Strobes decoded by the next-state logic and consumed by the datapath.
  logic accept;
  logic frame_hit;
  logic capture;
  logic timeout_hit;

  assign s_ready = Rst & (state_q == ST_FILL);
  assign busy    = (state_q != ST_FILL);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    frame_hit   = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (s_valid && s_ready) begin
          accept = 1'b1;
          if (s_last && (cnt_q == CNT_LAST)) state_d = ST_START;
          // s_last early, or missing on the final slot: drop the window.
          else if (s_last || (cnt_q == CNT_LAST)) frame_hit = 1'b1;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // finalReady may still be high from the previous window until the
        // guard has run out, so it is only trusted once guard reaches zero.
        if ((guard_q == '0) && finalReady) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end else if (tmo_q == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_FILL;
        end
      end
      ST_OUT: begin
        if (m_ready) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand slots
  // ---------------------------------------------------------------------------
  // NOTE: the slot array is explicitly reset because the accelerator sees it
  // directly and must read zeros out of reset; a storage array with no such
  // observer would normally be left unreset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < N; i++) begin
        slot_a[i] <= '0;
        slot_b[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          slot_a[i] <= AXI_BUS_WIDTH'($signed(s_multiplier));
          slot_b[i] <= AXI_BUS_WIDTH'($signed(s_multiplicand));
        end
      end
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_pack
    assign multiplier_input[n*AXI_BUS_WIDTH +: AXI_BUS_WIDTH]   = slot_a[n];
    assign multiplicand_input[n*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] = slot_b[n];
  end

  // ---------------------------------------------------------------------------
  // Slot counter, start pulse, guard and timeout counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q   <= '0;
      mStart  <= '0;
      guard_q <= '0;
      tmo_q   <= '0;
    end else begin
      if (accept) begin
        if ((state_d == ST_START) || frame_hit) cnt_q <= '0;
        else                                    cnt_q <= cnt_q + 1'b1;
      end

      // Registered so the pulse lines up with the START cycle.
      mStart <= {N{state_d == ST_START}};

      if (state_q == ST_START) begin
        guard_q <= GUARD_INIT;
        tmo_q   <= '0;
      end else if (state_q == ST_WAIT) begin
        if (guard_q != '0) guard_q <= guard_q - 1'b1;
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result port
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= finalAccumulate;
      end else if ((state_q == ST_OUT) && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error outranks a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_hit)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_window_feeder
//
// Self-checking bench for mac_window_feeder with default parameters. Inputs
// are driven 1 ns after each rising edge and outputs are sampled at the same
// point, so every sample reflects the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_mac_window_feeder;

  localparam int DW = 16;
  localparam int KS = 3;
  localparam int N  = KS * KS;
  localparam int AW = 32;
  localparam int SG = 2;
  localparam int TO = 255;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_multiplier;
  logic [DW-1:0]   s_multiplicand;
  logic            s_last;
  logic [N*AW-1:0] multiplier_input;
  logic [N*AW-1:0] multiplicand_input;
  logic [N-1:0]    mStart;
  logic            finalReady;
  logic [AW-1:0]   finalAccumulate;
  logic            m_valid;
  logic            m_ready;
  logic [AW-1:0]   m_data;
  logic            busy;
  logic            frame_err;
  logic            timeout_err;
  logic            err_clr;

  mac_window_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .AXI_BUS_WIDTH(AW),
    .START_GUARD(SG), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_multiplier(s_multiplier), .s_multiplicand(s_multiplicand), .s_last(s_last),
    .multiplier_input(multiplier_input), .multiplicand_input(multiplicand_input),
    .mStart(mStart), .finalReady(finalReady), .finalAccumulate(finalAccumulate),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic exp_frame = 1'b0;

  // Current window contents as seen by the reference model.
  logic [DW-1:0] win_a [N];
  logic [DW-1:0] win_b [N];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] exp_b;
  } vec_t;

  vec_t tbl [N];

  task automatic check(input string name, input logic [N*AW-1:0] act,
                       input logic [N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Sign extension computed through integer arithmetic.
  function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
    int s;
    s = $signed(v);
    return s;
  endfunction

  // Presents one pair; the feeder is expected to be collecting, so the beat
  // is accepted on the coming edge.
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic last);
    check("s_ready_fill", s_ready, 1'b1);
    check("no_mstart_fill", mStart, '0);
    s_valid        = 1'b1;
    s_multiplier   = a;
    s_multiplicand = b;
    s_last         = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_list(input int count, input int last_pos, input int max_gap);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      send_beat(win_a[i], win_b[i], i == last_pos);
    end
  endtask

  task automatic check_slots();
    for (int n = 0; n < N; n++) begin
      check($sformatf("slot_a[%0d]", n), multiplier_input[n*AW +: AW], sext(win_a[n]));
      check($sformatf("slot_b[%0d]", n), multiplicand_input[n*AW +: AW], sext(win_b[n]));
    end
  endtask

  // Called at the sample right after the final beat (the START cycle, t=0).
  // Accelerator model: finalReady carries a stale level through the guard
  // cycles, then rises at cycle t_fr and stays up. The feeder captures on the
  // edge ending cycle t_fr, so m_valid appears at sample t_fr+1.
  task automatic run_accel(input int t_fr, input logic stale, input logic [AW-1:0] v,
                           input int hold);
    check("mstart_pulse", mStart, {N{1'b1}});
    check("busy_start", busy, 1'b1);
    check("s_ready_start", s_ready, 1'b0);
    finalAccumulate = v;
    for (int t = 0; t <= t_fr; t++) begin
      finalReady = (t <= SG) ? stale : (t >= t_fr);
      if (t > 0) begin
        check("no_early_valid", m_valid, 1'b0);
        check("mstart_one_cycle", mStart, '0);
      end
      tick();
    end
    check("m_valid_up", m_valid, 1'b1);
    check("m_data", m_data, v);
    finalReady      = 1'b0;
    finalAccumulate = ~v;
    m_ready         = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", m_data, v);
      check("hold_s_ready", s_ready, 1'b0);
      check("hold_no_mstart", mStart, '0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("m_valid_drop", m_valid, 1'b0);
    check("s_ready_back", s_ready, 1'b1);
    check("busy_back", busy, 1'b0);
  endtask

  initial begin
    Rst             = 1'b0;
    s_valid         = 1'b0;
    s_multiplier    = '0;
    s_multiplicand  = '0;
    s_last          = 1'b0;
    finalReady      = 1'b0;
    finalAccumulate = '0;
    m_ready         = 1'b0;
    err_clr         = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_mstart", mStart, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_mult_in", multiplier_input, '0);
    check("rst_mcand_in", multiplicand_input, '0);
    Rst = 1'b1;
    tick();
    check("rel_s_ready", s_ready, 1'b1);
    check("rel_busy", busy, 1'b0);

    // ---- table-driven sign-extension window ----
    tbl[0] = '{16'hFFFD, 16'h0003, 32'hFFFFFFFD, 32'h00000003};
    tbl[1] = '{16'h7FFF, 16'h8000, 32'h00007FFF, 32'hFFFF8000};
    tbl[2] = '{16'h0000, 16'hFFFF, 32'h00000000, 32'hFFFFFFFF};
    tbl[3] = '{16'h0001, 16'h8001, 32'h00000001, 32'hFFFF8001};
    tbl[4] = '{16'h1234, 16'hABCD, 32'h00001234, 32'hFFFFABCD};
    tbl[5] = '{16'h8000, 16'h7FFE, 32'hFFFF8000, 32'h00007FFE};
    tbl[6] = '{16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{16'h00FF, 16'hFF00, 32'h000000FF, 32'hFFFFFF00};
    tbl[8] = '{16'h4000, 16'hC000, 32'h00004000, 32'hFFFFC000};
    for (int i = 0; i < N; i++) send_beat(tbl[i].a, tbl[i].b, i == N - 1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("tbl_a[%0d]", i), multiplier_input[i*AW +: AW], tbl[i].exp_a);
      check($sformatf("tbl_b[%0d]", i), multiplicand_input[i*AW +: AW], tbl[i].exp_b);
    end
    run_accel(SG + 1, 1'b0, 32'h8000_0000, 0);

    // ---- nine pairs (n+1, 2), result 90 four cycles after mStart ----
    for (int n = 0; n < N; n++) begin
      win_a[n] = DW'(n + 1);
      win_b[n] = 16'd2;
    end
    send_list(N, N - 1, 0);
    check_slots();
    run_accel(4, 1'b0, 32'd90, 0);

    // ---- 10 cycles of back-pressure with a stale finalReady ----
    for (int n = 0; n < N; n++) begin
      win_a[n] = DW'($urandom);
      win_b[n] = DW'($urandom);
    end
    send_list(N, N - 1, 1);
    check_slots();
    run_accel(SG + 3, 1'b1, 32'hDEAD_BEEF, 10);

    // ---- s_last on beat 5: window dropped, then a clean window ----
    send_list(5, 4, 0);
    check("frame_err_set", frame_err, 1'b1);
    check("frame_no_mstart", mStart, '0);
    check("frame_not_busy", busy, 1'b0);
    for (int n = 0; n < N; n++) begin
      win_a[n] = DW'($urandom);
      win_b[n] = DW'($urandom);
    end
    send_list(N, N - 1, 0);
    check_slots();
    run_accel(SG + 2, 1'b0, 32'h0000_1234, 0);
    check("frame_err_sticky", frame_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("frame_err_clr", frame_err, 1'b0);

    // ---- err_clr on the same edge as a new framing error ----
    err_clr = 1'b1;
    send_beat(16'h0, 16'h0, 1'b1);
    err_clr = 1'b0;
    check("err_beats_clr", frame_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("frame_err_clr2", frame_err, 1'b0);

    // ---- timeout: stale finalReady then silence ----
    send_list(N, N - 1, 0);
    check("to_mstart", mStart, {N{1'b1}});
    finalReady = 1'b1;
    for (int t = 0; t < TO; t++) begin
      if (t > SG) finalReady = 1'b0;
      tick();
      check("to_no_valid", m_valid, 1'b0);
    end
    check("to_still_busy", busy, 1'b1);
    check("to_not_yet", timeout_err, 1'b0);
    tick();
    check("to_err_set", timeout_err, 1'b1);
    check("to_back_fill", busy, 1'b0);
    check("to_s_ready", s_ready, 1'b1);
    check("to_m_valid", m_valid, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", timeout_err, 1'b0);

    // ---- reset mid-window, then reset during WAIT ----
    for (int n = 0; n < N; n++) begin
      win_a[n] = DW'(n + 7);
      win_b[n] = DW'(n + 100);
    end
    send_list(4, -1, 0);
    Rst = 1'b0;
    tick();
    check("midrst_slots", multiplier_input, '0);
    check("midrst_s_ready", s_ready, 1'b0);
    Rst = 1'b1;
    tick();
    send_list(N, N - 1, 0);
    check("postrst_mstart", mStart, {N{1'b1}});
    check_slots();
    tick();
    Rst = 1'b0;
    tick();
    Rst        = 1'b1;
    finalReady = 1'b1;
    check("waitrst_busy", busy, 1'b0);
    check("waitrst_m_data", m_data, '0);
    repeat (SG + 3) tick();
    finalReady = 1'b0;
    check("waitrst_dropped", m_valid, 1'b0);
    check("waitrst_idle", busy, 1'b0);

    // ---- randomized windows against the transaction-level model ----
    for (int w = 0; w < 30; w++) begin
      for (int n = 0; n < N; n++) begin
        win_a[n] = DW'($urandom);
        win_b[n] = DW'($urandom);
      end
      if ($urandom_range(3, 0) == 0) begin
        int pos;
        pos = $urandom_range(N - 1, 0);
        if (pos < N - 1) send_list(pos + 1, pos, 2);
        else             send_list(N, -1, 2);
        exp_frame = 1'b1;
        check("rnd_frame_err", frame_err, 1'b1);
        check("rnd_frame_idle", busy, 1'b0);
        check("rnd_frame_no_start", mStart, '0);
        if ($urandom_range(1, 0) == 1) begin
          err_clr = 1'b1;
          tick();
          err_clr   = 1'b0;
          exp_frame = 1'b0;
          check("rnd_frame_clr", frame_err, 1'b0);
        end
      end else begin
        send_list(N, N - 1, 2);
        check_slots();
        run_accel($urandom_range(SG + 6, SG + 1), 1'($urandom_range(1, 0)),
                  AW'($urandom), $urandom_range(4, 0));
        check("rnd_frame_flag", frame_err, exp_frame);
        check("rnd_timeout_flag", timeout_err, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
